// File: rtl/vga_delay_line.sv
// Tap-selectable delay line for VGA sync/blank/RGB with fill tracking and idle output levels.
// Optional synchronous line clear input `flush` when VGA_DELAY_FLUSH_EN is defined.
module vga_delay_line #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned DEPTH     = 4,
    parameter logic        SYNC_IDLE = 1'b0,
    localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              pclk,
    input  logic              rst_n,
`ifdef VGA_DELAY_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [SEL_W-1:0]  delay_sel,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic              primed
);

    localparam int unsigned      STG_W     = DATA_W + 4;
    localparam logic [STG_W-1:0] IDLE_WORD = {SYNC_IDLE, SYNC_IDLE, 2'b11, {DATA_W{1'b0}}};
    localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

    logic [STG_W-1:0] r_stage [1:DEPTH];
    logic [DEPTH:1]   r_valid;
    logic             w_clear;
    logic [SEL_W-1:0] w_d_eff;
    logic [STG_W-1:0] w_tap;
    logic             w_tap_valid;

`ifdef VGA_DELAY_FLUSH_EN
    assign w_clear = flush;
`else
    assign w_clear = 1'b0;
`endif

    // NOTE: every stage is reset, not just the valid bits, so the line holds defined idle levels.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_stage[k] <= IDLE_WORD;
            end
            r_valid <= '0;
        end else if (w_clear) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_stage[k] <= IDLE_WORD;
            end
            r_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture its predecessor's old value.
            r_stage[1] <= {hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
            r_valid[1] <= 1'b1;
            for (int k = 2; k <= DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    always_comb begin
        if (delay_sel == '0) begin
            w_d_eff = SEL_W'(1);
        end else if (delay_sel > DEPTH_SEL) begin
            w_d_eff = DEPTH_SEL;
        end else begin
            w_d_eff = delay_sel;
        end
    end

    // NOTE: defaults first so no path through the tap mux infers a latch.
    always_comb begin
        w_tap       = IDLE_WORD;
        w_tap_valid = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (w_d_eff == SEL_W'(k)) begin
                w_tap       = r_stage[k];
                w_tap_valid = r_valid[k];
            end
        end
    end

    assign primed = w_tap_valid;
    assign {hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} = w_tap_valid ? w_tap : IDLE_WORD;

endmodule
